secuenciador_nucleo: RTL

- Control sequencer directly upstream of the execution core.
- Scans the (n, m) index space of a frame and produces the core's stage enables (E1 capture, E2 capture).
- Dispatches each encoded result round-robin to serial ports 1..3: latches it into the port register, raises that port's enable, and frees the port when its finish flag returns.
- Holds the pipeline when the target port is still shifting.

---
 rtl/nucleo_pkg.sv | 28 ++
 rtl/gestor_puertos.sv | 42 ++++
 rtl/secuenciador_nucleo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nucleo_pkg.sv
// Shared types and constants for the core sequencer: FSM states, index and port widths.
package nucleo_pkg;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned NPS   = 3;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    S_E1,
    S_E2,
    S_WAIT,
    S_LOAD,
    S_ADV,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [NPS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NPS-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NPS; k++) begin
      if (s == SEL_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/gestor_puertos.sv
// Serial port bookkeeping: shift-enable flags, set on load, released by the port's finish flag.
module gestor_puertos
  import nucleo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_abort,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [NPS-1:0]   i_fin,
  output logic [NPS-1:0]   o_en,
  output logic [NPS-1:0]   o_free,
  output logic             o_all_idle
);

  logic [NPS-1:0] r_en;
  logic [NPS-1:0] w_set;
  logic [NPS-1:0] w_clr;

  always_comb begin
    w_set = i_load ? sel_onehot(i_sel) : '0;
    // finish flags are only honoured on ports that are actually shifting
    w_clr = r_en & i_fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
    end else if (i_abort) begin
      r_en <= '0;
    end else begin
      r_en <= (r_en & ~w_clr) | w_set;
    end
  end

  assign o_en       = r_en;
  assign o_free     = ~r_en;
  assign o_all_idle = (r_en == '0);

  a_no_set_clr: assert property (@(posedge clk) disable iff (!rst_n) (w_set & w_clr) == '0);

endmodule

// File: rtl/secuenciador_nucleo.sv
// Frame scanner feeding the execution core: issues stage enables per (n, m) element
// and dispatches each result round-robin to three serial ports.
module secuenciador_nucleo
  import nucleo_pkg::*;
(
  input  logic             clkMC,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] n_max,
  input  logic [IDX_W-1:0] m_max,
  input  logic             sPS1,
  input  logic             sPS2,
  input  logic             sPS3,
  output logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] m,
  output logic             enclkE1,
  output logic             enclkE2,
  output logic             enclkPS1reg,
  output logic             enclkPS2reg,
  output logic             enclkPS3reg,
  output logic             enPS1,
  output logic             enPS2,
  output logic             enPS3,
  output logic [SEL_W-1:0] selDM,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [IDX_W-1:0] r_n;
  logic [IDX_W-1:0] r_m;
  logic [IDX_W-1:0] r_n_max;
  logic [IDX_W-1:0] r_m_max;
  logic [SEL_W-1:0] r_sel;
  logic             r_enclkE1;
  logic             r_enclkE2;
  logic [NPS-1:0]   r_enclkPSreg;
  logic             r_busy;
  logic             r_done;

  logic [NPS-1:0]   w_en;
  logic [NPS-1:0]   w_free;
  logic             w_all_idle;
  logic             w_load;
  logic             w_last;

  assign w_load = (r_state == S_LOAD);
  assign w_last = (r_n == r_n_max) && (r_m == r_m_max);

  gestor_puertos u_puertos (
    .clk        (clkMC),
    .rst_n      (rst),
    .i_abort    (abort),
    .i_load     (w_load),
    .i_sel      (r_sel),
    .i_fin      ({sPS3, sPS2, sPS1}),
    .o_en       (w_en),
    .o_free     (w_free),
    .o_all_idle (w_all_idle)
  );

  // Pulse outputs are registered on entry to the state they belong to.
  always_ff @(posedge clkMC or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_m          <= '0;
      r_n_max      <= '0;
      r_m_max      <= '0;
      r_sel        <= '0;
      r_enclkE1    <= 1'b0;
      r_enclkE2    <= 1'b0;
      r_enclkPSreg <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_enclkE1    <= 1'b0;
      r_enclkE2    <= 1'b0;
      r_enclkPSreg <= '0;
      r_done       <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start) begin
              r_n_max   <= n_max;
              r_m_max   <= m_max;
              r_n       <= '0;
              r_m       <= '0;
              r_sel     <= '0;
              r_state   <= S_E1;
              r_enclkE1 <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          S_E1: begin
            r_state   <= S_E2;
            r_enclkE2 <= 1'b1;
          end
          S_E2: r_state <= S_WAIT;
          S_WAIT: begin
            if (w_free[r_sel]) begin
              r_state      <= S_LOAD;
              r_enclkPSreg <= sel_onehot(r_sel);
            end
          end
          S_LOAD: r_state <= S_ADV;
          S_ADV: begin
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              if (r_m == r_m_max) begin
                r_m <= '0;
                r_n <= r_n + IDX_W'(1);
              end else begin
                r_m <= r_m + IDX_W'(1);
              end
              r_sel     <= (r_sel == SEL_W'(NPS - 1)) ? '0 : r_sel + SEL_W'(1);
              r_state   <= S_E1;
              r_enclkE1 <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_all_idle) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign n           = r_n;
  assign m           = r_m;
  assign selDM       = r_sel;
  assign enclkE1     = r_enclkE1;
  assign enclkE2     = r_enclkE2;
  assign enclkPS1reg = r_enclkPSreg[0];
  assign enclkPS2reg = r_enclkPSreg[1];
  assign enclkPS3reg = r_enclkPSreg[2];
  assign enPS1       = w_en[0];
  assign enPS2       = w_en[1];
  assign enPS3       = w_en[2];
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
